std_div_pipe_4: RTL and testbench

- Iterative unsigned restoring divider with a go/done handshake.
- Produces a 4-bit quotient and a 4-bit remainder, one quotient bit per cycle.
- Sits directly upstream of the 4-bit registers: its done pulse drives the register write_en, and out_quotient / out_remainder drive the register data input.
- Schedule: a control FSM asserts go and holds it until it sees done.

---
 rtl/std_div_pkg.sv | 25 ++
 rtl/std_div_pipe_4_div_step.sv | 34 +++
 rtl/std_div_pipe_4.sv | 132 +++++++++++++
 tb/tb_std_div_pipe_4.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/std_div_pkg.sv
//------------------------------------------------------------------------------
// Module  : std_div_pkg
// Brief   : Shared types and sizing helpers for the iterative divider.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package std_div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // One extra bit so the counter can hold WIDTH itself for any WIDTH.
    function automatic int div_cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/std_div_pipe_4_div_step.sv
//------------------------------------------------------------------------------
// Module  : div_step
// Brief   : One combinational restoring-division iteration.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module div_step
    import std_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             dividend_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             quot_bit
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;

    // The partial remainder is always below the divisor, so the shifted
    // value fits in WIDTH+1 bits and the top bit shifted out is zero.
    always_comb begin
        w_shifted = (rem_in << 1) | {{WIDTH{1'b0}}, dividend_msb};
        w_diff    = w_shifted - {1'b0, divisor};
        quot_bit  = (w_shifted >= {1'b0, divisor});
        rem_out   = quot_bit ? w_diff : w_shifted;
    end

endmodule

`default_nettype wire

// File: rtl/std_div_pipe_4.sv
//------------------------------------------------------------------------------
// Module  : std_div_pipe_4
// Brief   : Iterative unsigned restoring divider, go/done handshake.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module std_div_pipe_4
    import std_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             done
);

    localparam int CNT_W = div_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST_ITER = CNT_W'(WIDTH - 1);

    div_state_t       r_state;
    div_state_t       w_state_next;
    logic             w_capture;
    logic             w_iterate;
    logic             w_finish;

    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quot;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic [WIDTH-1:0] r_out_quot;
    logic [WIDTH-1:0] r_out_rem;

    logic [WIDTH:0]   w_rem_next;
    logic             w_qbit;
    logic [WIDTH-1:0] w_quot_next;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in       (r_rem),
        .dividend_msb (r_dividend[WIDTH-1]),
        .divisor      (r_divisor),
        .rem_out      (w_rem_next),
        .quot_bit     (w_qbit)
    );

    assign w_quot_next = (r_quot << 1) | {{(WIDTH-1){1'b0}}, w_qbit};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_iterate    = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE: begin
                if (go) begin
                    w_capture    = 1'b1;
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                w_iterate = 1'b1;
                if (r_cnt == C_LAST_ITER) begin
                    w_finish     = 1'b1;
                    w_state_next = DONE;
                end
            end
            // go is deliberately not looked at here, so a held request
            // cannot restart the divider during the completion cycle.
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dividend <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_out_quot <= '0;
            r_out_rem  <= '0;
        end else begin
            r_done <= w_finish;
            if (w_capture) begin
                r_dividend <= left;
                r_divisor  <= right;
                r_rem      <= '0;
                r_quot     <= '0;
                r_cnt      <= '0;
            end else if (w_iterate) begin
                r_dividend <= r_dividend << 1;
                r_rem      <= w_rem_next;
                r_quot     <= w_quot_next;
                r_cnt      <= r_cnt + 1'b1;
            end
            if (w_finish) begin
                r_out_quot <= w_quot_next;
                r_out_rem  <= w_rem_next[WIDTH-1:0];
            end
        end
    end

    assign out_quotient  = r_out_quot;
    assign out_remainder = r_out_rem;
    assign done          = r_done;

endmodule

`default_nettype wire

// File: tb/tb_std_div_pipe_4.sv
//------------------------------------------------------------------------------
// Module  : tb_std_div_pipe_4
// Brief   : Scoreboard bench for std_div_pipe_4 plus a downstream register.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_std_div_pipe_4;

    localparam int WIDTH = 4;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        int               cyc;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             go;
    logic [WIDTH-1:0] left;
    logic [WIDTH-1:0] right;
    logic [WIDTH-1:0] out_quotient;
    logic [WIDTH-1:0] out_remainder;
    logic             done;

    logic [WIDTH-1:0] reg_q;
    logic             reg_done;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] reg_exp_q[$];
    int               cyc;
    int               last_done_cyc;
    int               compared;
    int               mismatched;

    std_div_pipe_4 #(
        .WIDTH (WIDTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .go            (go),
        .left          (left),
        .right         (right),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .done          (done)
    );

    // Downstream register: done is its write enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_q    <= '0;
            reg_done <= 1'b0;
        end else begin
            reg_done <= done;
            if (done) reg_q <= out_quotient;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the divider or register reports done.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                last_done_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("quotient", int'(out_quotient), int'(e.q));
                    check("remainder", int'(out_remainder), int'(e.r));
                    check("done_latency", cyc, e.cyc);
                end
            end
            if (reg_done) begin
                check("reg_done_follows", cyc, last_done_cyc + 1);
                if (reg_exp_q.size() == 0) begin
                    check("unexpected_reg_write", 1, 0);
                end else begin
                    logic [WIDTH-1:0] rq;
                    rq = reg_exp_q.pop_front();
                    check("reg_captured_q", int'(reg_q), int'(rq));
                end
            end
        end
    end

    task automatic push_exp(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r);
        exp_t e;
        e.q   = q;
        e.r   = r;
        e.cyc = cyc + WIDTH;
        exp_q.push_back(e);
        reg_exp_q.push_back(q);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic run_div(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] rr,
                           input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er);
        @(negedge clk);
        left  = l;
        right = rr;
        go    = 1'b1;
        @(posedge clk);
        #1 push_exp(eq, er);
        wait_done();
        go = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    logic [WIDTH-1:0] bb_l [4];
    logic [WIDTH-1:0] bb_r [4];
    logic [WIDTH-1:0] bb_q [4];
    logic [WIDTH-1:0] bb_m [4];

    initial begin
        compared   = 0;
        mismatched = 0;
        last_done_cyc = -10;
        reset = 1'b1;
        go    = 1'b0;
        left  = '0;
        right = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_quotient", int'(out_quotient), 0);
        check("reset_remainder", int'(out_remainder), 0);
        check("reset_done", int'(done), 0);
        #1 reset = 1'b0;

        run_div(4'd13, 4'd3, 4'd4,  4'd1);
        run_div(4'd15, 4'd1, 4'd15, 4'd0);
        run_div(4'd2,  4'd5, 4'd0,  4'd2);
        run_div(4'd0,  4'd7, 4'd0,  4'd0);
        run_div(4'd7,  4'd0, 4'd15, 4'd7);

        // go held through done, dividend changed after capture.
        @(negedge clk);
        left = 4'd9; right = 4'd2; go = 1'b1;
        @(posedge clk);
        #1 push_exp(4'd4, 4'd1);
        @(posedge clk);
        @(posedge clk);
        #1 left = 4'd15;
        wait_done();
        @(posedge clk);
        #1 go = 1'b0;
        repeat (10) @(negedge clk);
        check("no_restart_from_done", exp_q.size(), 0);

        // Reset mid-operation aborts with no done pulse.
        @(negedge clk);
        left = 4'd14; right = 4'd3; go = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 begin reset = 1'b1; go = 1'b0; end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_quotient", int'(out_quotient), 0);
        check("abort_remainder", int'(out_remainder), 0);
        check("abort_done", int'(done), 0);
        repeat (8) @(negedge clk);
        run_div(4'd14, 4'd3, 4'd4, 4'd2);

        // Back-to-back at minimum spacing, go held continuously.
        bb_l = '{4'd11, 4'd12, 4'd10, 4'd6};
        bb_r = '{4'd2,  4'd4,  4'd3,  4'd7};
        bb_q = '{4'd5,  4'd3,  4'd3,  4'd0};
        bb_m = '{4'd1,  4'd0,  4'd1,  4'd6};
        @(negedge clk);
        left = bb_l[0]; right = bb_r[0]; go = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1 push_exp(bb_q[k], bb_m[k]);
            if (k < 3) begin
                left  = bb_l[k+1];
                right = bb_r[k+1];
            end else begin
                go = 1'b0;
            end
            repeat (WIDTH + 1) @(posedge clk);
        end
        repeat (6) @(negedge clk);

        check("scoreboard_drained", exp_q.size(), 0);
        check("reg_scoreboard_drained", reg_exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
